// File: rtl/opo_package.sv
// Shared constants for the filter-cascade control blocks.
//   word_width          : width of sample-count style fields (settle length/counter)
//   default_num_stages  : default number of cascaded 2-sample averaging stages
package opo_package;

  localparam int word_width         = 16;
  localparam int default_num_stages = 8;

endpackage

// File: rtl/lpf_stage_sequencer.sv
// lpf_stage_sequencer
//   Ramps a cascade of 2-sample averaging stages on or off one stage at a time.
//   After every single-stage change it waits for a programmable number of
//   filter output samples before taking the next step, so the cascade output
//   never sees more than one structural change at a time.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   cfg_stages   : requested number of enabled stages (clamped to num_stages)
//   cfg_settle   : filter output samples to wait after each stage change
//   cfg_valid    : configuration request
//   cfg_ready    : high only while idle; request accepted when both high
//   abort        : cancels an in-progress ramp (holds current enables)
//   filt_valid   : sample_out_valid from the controlled cascade
//   stage_enable : thermometer-coded stage enables to the cascade
//   cur_stages   : number of stages currently enabled
//   settled      : level, high once the requested target has been reached
//   done_pulse   : one-cycle strobe on ramp completion
module lpf_stage_sequencer
  import opo_package::*;
#(
  parameter int num_stages = default_num_stages,
  parameter int cnt_w      = $clog2(num_stages + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [cnt_w-1:0]      cfg_stages,
  input  logic [word_width-1:0] cfg_settle,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  abort,
  input  logic                  filt_valid,
  output logic [num_stages-1:0] stage_enable,
  output logic [cnt_w-1:0]      cur_stages,
  output logic                  settled,
  output logic                  done_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE
  } state_t;

  state_t                state;
  logic [cnt_w-1:0]      target_stages;
  logic [word_width-1:0] settle_len;
  logic [word_width-1:0] settle_cnt;
  logic [cnt_w-1:0]      cur_inc;
  logic [cnt_w-1:0]      cur_dec;
  logic                  xfer;

  // Thermometer code: the lowest n bits set.
  function automatic logic [num_stages-1:0] therm(input logic [cnt_w-1:0] n);
    logic [num_stages-1:0] t;
    for (int i = 0; i < num_stages; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

  // Requests beyond the physical cascade length saturate at num_stages.
  function automatic logic [cnt_w-1:0] clamp_stages(input logic [cnt_w-1:0] req);
    if (int'(req) > num_stages) begin
      return cnt_w'(num_stages);
    end
    return req;
  endfunction

  assign cfg_ready = (state == S_IDLE);
  // abort wins over a simultaneous request, which is then simply dropped
  assign xfer      = cfg_ready && cfg_valid && !abort;
  assign cur_inc   = cur_stages + 1'b1;
  assign cur_dec   = cur_stages - 1'b1;

  // Settle length is configuration data only; it is always rewritten on a
  // transfer before it is ever used, so it carries no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      settle_len <= cfg_settle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cur_stages    <= '0;
      stage_enable  <= '0;
      target_stages <= '0;
      settle_cnt    <= '0;
      settled       <= 1'b1;
      done_pulse    <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            target_stages <= clamp_stages(cfg_stages);
            settled       <= 1'b0;
            state         <= S_STEP;
          end
        end

        S_STEP: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (cur_stages < target_stages) begin
            cur_stages   <= cur_inc;
            stage_enable <= therm(cur_inc);
            settle_cnt   <= '0;
            state        <= S_SETTLE;
          end else if (cur_stages > target_stages) begin
            cur_stages   <= cur_dec;
            stage_enable <= therm(cur_dec);
            settle_cnt   <= '0;
            state        <= S_SETTLE;
          end else begin
            settled    <= 1'b1;
            done_pulse <= 1'b1;
            state      <= S_IDLE;
          end
        end

        S_SETTLE: begin
          // The counter stops at settle_len, so it never wraps even for 65535.
          if (abort) begin
            state <= S_IDLE;
          end else if (settle_cnt == settle_len) begin
            state <= S_STEP;
          end else if (filt_valid) begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpf_stage_sequencer.sv
// Self-checking bench for lpf_stage_sequencer: directed table of ramps,
// randomized ramps against a transaction-level timeline model, and
// hand-written abort / stall / reset / long-settle sequences.
module tb_lpf_stage_sequencer;

  localparam int NS = 8;
  localparam int CW = 4;
  localparam int FVN = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_stages;
  logic [15:0]   cfg_settle;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          abort;
  logic          filt_valid;
  logic [NS-1:0] stage_enable;
  logic [CW-1:0] cur_stages;
  logic          settled;
  logic          done_pulse;

  int total  = 0;
  int passed = 0;
  int model_cur = 0;

  typedef struct {
    int req;
    int settle;
    int exp_done_rel;
    int exp_en;
    int exp_cur;
  } vec_t;

  vec_t tbl[7];

  int fv[FVN];
  int e_en[FVN];
  int e_done[FVN];
  int e_set[FVN];
  int e_rdy[FVN];

  always #5 clk = ~clk;

  lpf_stage_sequencer #(.num_stages(NS), .cnt_w(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_stages   (cfg_stages),
    .cfg_settle   (cfg_settle),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .abort        (abort),
    .filt_valid   (filt_valid),
    .stage_enable (stage_enable),
    .cur_stages   (cur_stages),
    .settled      (settled),
    .done_pulse   (done_pulse)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int therm_val(input int n);
    return (1 << n) - 1;
  endfunction

  function automatic int fvat(input int i);
    return (i < FVN) ? fv[i] : 1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Ramp with filt_valid held high; measures cycles from transfer to done_pulse.
  task automatic run_ramp(input string tag, input vec_t v, input int bound);
    int got;
    cfg_valid  = 1'b1;
    cfg_stages = CW'(v.req);
    cfg_settle = 16'(v.settle);
    filt_valid = 1'b1;
    abort      = 1'b0;
    @(negedge clk);
    check({tag, " ready at transfer"}, int'(cfg_ready), 1);
    next_cycle();
    cfg_valid = 1'b0;
    got = -1;
    for (int r = 1; r <= bound; r++) begin
      @(negedge clk);
      if (done_pulse) begin
        got = r;
        break;
      end
      next_cycle();
    end
    check({tag, " done latency"}, got, v.exp_done_rel);
    check({tag, " final enable"}, int'(stage_enable), v.exp_en);
    check({tag, " final cur"}, int'(cur_stages), v.exp_cur);
    check({tag, " settled"}, int'(settled), 1);
    check({tag, " ready"}, int'(cfg_ready), 1);
    next_cycle();
    @(negedge clk);
    check({tag, " done one cycle"}, int'(done_pulse), 0);
    next_cycle();
    model_cur = v.exp_cur;
  endtask

  // Random ramp checked cycle by cycle against a timeline built from the
  // rules: one STEP cycle per move, then SETTLE until the requested number
  // of valid samples has been seen, plus one cycle.
  task automatic run_random(input int idx);
    int req, tgt, len, t, cur, s, j, cnt, last;
    req = int'($urandom_range(0, 15));
    len = int'($urandom_range(0, 4));
    tgt = (req > NS) ? NS : req;
    for (int i = 0; i < FVN; i++) fv[i] = int'($urandom_range(0, 1));
    t = 1;
    cur = model_cur;
    last = 0;
    while (t < FVN - 2) begin
      e_en[t] = therm_val(cur); e_done[t] = 0; e_set[t] = 0; e_rdy[t] = 0;
      if (cur == tgt) begin
        e_en[t+1] = therm_val(cur); e_done[t+1] = 1; e_set[t+1] = 1; e_rdy[t+1] = 1;
        last = t + 1;
        break;
      end
      cur = (tgt > cur) ? cur + 1 : cur - 1;
      s = t + 1;
      j = s;
      cnt = 0;
      while (cnt < len) begin
        cnt += fvat(j);
        j++;
      end
      for (int k = s; k <= j && k < FVN; k++) begin
        e_en[k] = therm_val(cur); e_done[k] = 0; e_set[k] = 0; e_rdy[k] = 0;
      end
      t = j + 1;
    end
    cfg_valid  = 1'b1;
    cfg_stages = CW'(req);
    cfg_settle = 16'(len);
    abort      = 1'b0;
    filt_valid = fvat(0) != 0;
    @(negedge clk);
    check($sformatf("rnd%0d ready at transfer", idx), int'(cfg_ready), 1);
    next_cycle();
    for (int r = 1; r <= last; r++) begin
      cfg_valid  = (r == last) ? 1'b0 : 1'($urandom_range(0, 1));
      cfg_stages = CW'($urandom_range(0, 15));
      cfg_settle = 16'($urandom_range(0, 65535));
      filt_valid = fvat(r) != 0;
      @(negedge clk);
      check($sformatf("rnd%0d en r%0d", idx, r), int'(stage_enable), e_en[r]);
      check($sformatf("rnd%0d done r%0d", idx, r), int'(done_pulse), e_done[r]);
      check($sformatf("rnd%0d settled r%0d", idx, r), int'(settled), e_set[r]);
      check($sformatf("rnd%0d ready r%0d", idx, r), int'(cfg_ready), e_rdy[r]);
      next_cycle();
    end
    cfg_valid = 1'b0;
    check($sformatf("rnd%0d terminated", idx), int'(last > 0), 1);
    model_cur = tgt;
  endtask

  initial begin
    int bad;
    vec_t lv;

    tbl[0] = '{3,  4, 20, 8'h07, 3};
    tbl[1] = '{1,  0,  6, 8'h01, 1};
    tbl[2] = '{12, 1, 23, 8'hFF, 8};
    tbl[3] = '{8,  3,  2, 8'hFF, 8};
    tbl[4] = '{0,  2, 34, 8'h00, 0};
    tbl[5] = '{15, 0, 18, 8'hFF, 8};
    tbl[6] = '{5,  1, 11, 8'h1F, 5};

    rst = 1'b1; cfg_valid = 1'b0; cfg_stages = '0; cfg_settle = '0;
    abort = 1'b0; filt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset enable", int'(stage_enable), 0);
    check("reset cur", int'(cur_stages), 0);
    check("reset settled", int'(settled), 1);
    check("reset done", int'(done_pulse), 0);
    check("reset ready", int'(cfg_ready), 1);
    next_cycle();

    for (int i = 0; i < 7; i++) run_ramp($sformatf("tbl%0d", i), tbl[i], 300);

    for (int i = 0; i < 12; i++) begin
      run_random(i);
      next_cycle();
    end

    // Abort mid-ramp at two enabled stages.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    cfg_valid = 1'b1; cfg_stages = 4'd5; cfg_settle = 16'd2; filt_valid = 1'b1;
    next_cycle();
    cfg_valid = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      if (r == 6) abort = 1'b1;
      @(negedge clk);
      if (r == 6) check("abort pre enable", int'(stage_enable), 8'h03);
      next_cycle();
    end
    abort = 1'b0;
    @(negedge clk);
    check("abort enable held", int'(stage_enable), 8'h03);
    check("abort cur held", int'(cur_stages), 2);
    check("abort settled low", int'(settled), 0);
    check("abort no done", int'(done_pulse), 0);
    check("abort ready", int'(cfg_ready), 1);
    next_cycle();
    bad = 0;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      if (done_pulse || stage_enable != 8'h03 || settled) bad++;
      next_cycle();
    end
    check("abort quiet cycles", bad, 0);

    // Abort together with a request: the request is dropped.
    cfg_valid = 1'b1; cfg_stages = 4'd7; abort = 1'b1;
    next_cycle();
    cfg_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort+xfer ready", int'(cfg_ready), 1);
    next_cycle();
    @(negedge clk);
    check("abort+xfer enable", int'(stage_enable), 8'h03);
    check("abort+xfer settled", int'(settled), 0);
    next_cycle();

    // Stall in SETTLE with filt_valid low; requests ignored.
    cfg_valid = 1'b1; cfg_stages = 4'd4; cfg_settle = 16'd2; filt_valid = 1'b0;
    next_cycle();
    cfg_valid = 1'b0;
    next_cycle();
    bad = 0;
    for (int r = 0; r < 30; r++) begin
      cfg_valid  = r[0];
      cfg_stages = CW'($urandom_range(0, 15));
      @(negedge clk);
      if (cfg_ready || stage_enable != 8'h07 || done_pulse) bad++;
      next_cycle();
    end
    cfg_valid = 1'b0;
    check("stall holds", bad, 0);

    // Reset during SETTLE discards the pending target.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    filt_valid = 1'b1;
    @(negedge clk);
    check("midramp rst enable", int'(stage_enable), 0);
    check("midramp rst cur", int'(cur_stages), 0);
    check("midramp rst settled", int'(settled), 1);
    check("midramp rst ready", int'(cfg_ready), 1);
    next_cycle();
    bad = 0;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      if (done_pulse || stage_enable != 0 || !cfg_ready) bad++;
      next_cycle();
    end
    check("post rst idle", bad, 0);
    model_cur = 0;

    // Maximum settle length: one step takes 1 + 65536 + 1 cycles.
    lv = '{1, 65535, 65539, 8'h01, 1};
    run_ramp("settle65535", lv, 70000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
